// File: rtl/dot_accel_mc.sv
// dot_accel_mc: Avalon-MM dot-product accelerator.
// A CSR slave configures weight/activation base addresses, a word count and a
// destination. The master fetches one weight word and one activation word at a
// time, multiply-accumulates LANES packed Q8.8 lanes, then writes the shifted,
// saturated (and optionally ReLU-clamped) 32-bit result back to memory.
//
// state | meaning
// IDLE  | waiting for a start write on CTRL
// RD_W  | weight read request on the bus, held until accepted
// WT_W  | waiting for the weight word to return
// RD_A  | activation read request on the bus, held until accepted
// WT_A  | waiting for the activation word to return
// MAC   | accumulate the lane products, advance the word index
// WR    | result write on the bus, held until accepted
// FIN   | publish RESULT, set done and irq

module dot_accel_mc #(
    parameter int LANES     = 2,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 48,
    parameter int ADDR_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            slave_address,
    input  logic                  slave_read,
    input  logic                  slave_write,
    input  logic [31:0]           slave_writedata,
    output logic [31:0]           slave_readdata,
    output logic [ADDR_W-1:0]     master_address,
    output logic                  master_read,
    output logic                  master_write,
    output logic [16*LANES-1:0]   master_writedata,
    input  logic [16*LANES-1:0]   master_readdata,
    input  logic                  master_readdatavalid,
    input  logic                  master_waitrequest,
    output logic                  irq
);

    localparam int MDW   = 16 * LANES;
    localparam int BYTES = MDW / 8;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sh7FFF_FFFF);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(32'sh8000_0000);

    typedef enum logic [2:0] {
        IDLE, RD_W, WT_W, RD_A, WT_A, MAC, WR, FIN
    } state_t;

    state_t state_q, state_d;

    logic [31:0]              wbase_q, abase_q, len_q, dest_q;
    logic                     mode_q;
    logic [31:0]              result_q;
    logic                     done_q;
    logic                     irq_q;
    logic [31:0]              idx_q;
    logic [MDW-1:0]           w_q, a_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [31:0]              rdata_q;

    logic                     busy;
    logic                     start;
    logic                     irq_clr;
    logic                     last_word;
    logic [ADDR_W-1:0]        word_off;
    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [31:0]       r_val;
    logic [31:0]              csr_rdata;

    // Control decode; start is only honoured in IDLE, so a start while busy is dropped.
    always_comb begin
        busy      = (state_q != IDLE);
        start     = slave_write && (slave_address == 3'd0) && slave_writedata[0] && !busy;
        irq_clr   = slave_write && (slave_address == 3'd0) && slave_writedata[1];
        last_word = (idx_q == (len_q - 32'd1));
        word_off  = ADDR_W'(idx_q) * ADDR_W'(BYTES);
    end

    // Sum of signed lane products for the current weight/activation pair.
    always_comb begin
        prod    = '0;
        mac_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            prod    = $signed(w_q[16*k +: 16]) * $signed(a_q[16*k +: 16]);
            mac_sum = mac_sum + ACC_W'(prod);
        end
    end

    // Rescale the accumulator, clamp to 32-bit signed, then apply the optional ReLU.
    always_comb begin
        shifted = acc_q >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            r_val = 32'sh7FFF_FFFF;
        end else if (shifted < SAT_MIN) begin
            r_val = 32'sh8000_0000;
        end else begin
            r_val = shifted[31:0];
        end
        if (mode_q && r_val[31]) begin
            r_val = '0;
        end
    end

    // Next-state logic for the fetch/accumulate/write sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (len_q == 32'd0) ? WR : RD_W;
            RD_W: if (!master_waitrequest) state_d = WT_W;
            WT_W: if (master_readdatavalid) state_d = RD_A;
            RD_A: if (!master_waitrequest) state_d = WT_A;
            WT_A: if (master_readdatavalid) state_d = MAC;
            MAC:  state_d = last_word ? WR : RD_W;
            WR:   if (!master_waitrequest) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Master outputs decode from the registered state, so reset drops them at once
    // and they stay constant through a stall.
    always_comb begin
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        case (state_q)
            RD_W: begin
                master_read    = 1'b1;
                master_address = ADDR_W'(wbase_q) + word_off;
            end
            RD_A: begin
                master_read    = 1'b1;
                master_address = ADDR_W'(abase_q) + word_off;
            end
            WR: begin
                master_write     = 1'b1;
                master_address   = ADDR_W'(dest_q);
                master_writedata = MDW'(r_val);
            end
            default: ;
        endcase
    end

    // CSR read mux.
    always_comb begin
        csr_rdata = '0;
        case (slave_address)
            3'd0: csr_rdata = {30'b0, done_q, busy};
            3'd1: csr_rdata = wbase_q;
            3'd2: csr_rdata = abase_q;
            3'd3: csr_rdata = len_q;
            3'd4: csr_rdata = dest_q;
            3'd5: csr_rdata = {31'b0, mode_q};
            3'd6: csr_rdata = result_q;
            default: csr_rdata = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CSRs, status flags and the registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbase_q  <= '0;
            abase_q  <= '0;
            len_q    <= '0;
            dest_q   <= '0;
            mode_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (slave_write && !busy) begin
                case (slave_address)
                    3'd1: wbase_q <= slave_writedata;
                    3'd2: abase_q <= slave_writedata;
                    3'd3: len_q   <= slave_writedata;
                    3'd4: dest_q  <= slave_writedata;
                    3'd5: mode_q  <= slave_writedata[0];
                    default: ;
                endcase
            end
            if (start) begin
                done_q <= 1'b0;
                irq_q  <= 1'b0;
            end else if (irq_clr) begin
                irq_q  <= 1'b0;
            end
            if (state_q == FIN) begin
                result_q <= r_val;
                done_q   <= 1'b1;
                irq_q    <= 1'b1;
            end
            if (slave_read) begin
                rdata_q <= csr_rdata;
            end
        end
    end

    // Datapath: operand capture, accumulation and word index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            w_q   <= '0;
            a_q   <= '0;
            acc_q <= '0;
        end else begin
            if (start) begin
                idx_q <= '0;
                acc_q <= '0;
            end
            if (state_q == WT_W && master_readdatavalid) begin
                w_q <= master_readdata;
            end
            if (state_q == WT_A && master_readdatavalid) begin
                a_q <= master_readdata;
            end
            if (state_q == MAC) begin
                acc_q <= acc_q + mac_sum;
                idx_q <= idx_q + 32'd1;
            end
        end
    end

    assign slave_readdata = rdata_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_dot_accel_mc.sv
// Bench for dot_accel_mc: directed jobs with hand-computed results. The stimulus
// pushes expected read addresses, result writes and CSR read values into queues;
// a bus-model process serves memory and pops/compares as the DUT presents them.

module tb_dot_accel_mc;

    localparam int LANES = 2;
    localparam int MDW   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        slave_address;
    logic              slave_read;
    logic              slave_write;
    logic [31:0]       slave_writedata;
    logic [31:0]       slave_readdata;
    logic [31:0]       master_address;
    logic              master_read;
    logic              master_write;
    logic [MDW-1:0]    master_writedata;
    logic [MDW-1:0]    master_readdata;
    logic              master_readdatavalid;
    logic              master_waitrequest;
    logic              irq;

    dot_accel_mc #(.LANES(LANES), .FRAC_BITS(8), .ACC_W(48), .ADDR_W(32)) dut (
        .clk                  (clk),
        .reset                (reset),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .slave_readdata       (slave_readdata),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_writedata     (master_writedata),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_waitrequest   (master_waitrequest),
        .irq                  (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_raddr[$];
    logic [31:0] exp_wr_addr[$];
    logic [31:0] exp_wr_data[$];
    logic [31:0] exp_csr[$];

    logic [31:0] mem [logic [31:0]];
    logic        fill_en = 1'b0;
    logic [31:0] fill_w = '0, fill_a = '0, fill_abase = '0;

    logic        rand_en = 1'b0;
    int          fix_delay = 0;
    logic        stray_req = 1'b0;
    logic [31:0] watch_addr = 32'hFFFF_FFFF;
    int          watch_cnt = 0;
    int          stall_viol = 0;
    int          outstanding_viol = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        if (fill_en) return (a >= fill_abase) ? fill_a : fill_w;
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Memory slave model and scoreboard monitor.
    initial begin : bus_model
        logic        pending;
        int          pend_cnt;
        logic [31:0] pend_data;
        logic        prev_stall;
        logic        p_rd, p_wr;
        logic [31:0] p_addr, p_wd;
        pending = 0; pend_cnt = 0; pend_data = '0; prev_stall = 0;
        p_rd = 0; p_wr = 0; p_addr = '0; p_wd = '0;
        master_waitrequest = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_stall && !reset) begin
                if (master_read !== p_rd || master_write !== p_wr || master_address !== p_addr ||
                    (p_wr && master_writedata !== p_wd))
                    stall_viol++;
            end
            master_readdatavalid = 1'b0;
            if (reset) begin
                pending = 0;
            end else if (stray_req) begin
                master_readdatavalid = 1'b1;
                master_readdata = 32'hDEAD_BEEF;
            end else if (pending) begin
                if (pend_cnt == 0) begin
                    master_readdatavalid = 1'b1;
                    master_readdata = pend_data;
                    pending = 0;
                end else begin
                    pend_cnt--;
                end
            end
            master_waitrequest = rand_en ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!reset && master_read && !master_waitrequest) begin
                if (pending) outstanding_viol++;
                pending   = 1;
                pend_cnt  = rand_en ? int'($urandom_range(0, 5)) : fix_delay;
                pend_data = mem_rd(master_address);
                if (master_address == watch_addr) watch_cnt++;
                if (exp_raddr.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_read: got 0x%0h, none expected", master_address);
                end else begin
                    check("read_addr", master_address, exp_raddr.pop_front());
                end
            end
            if (!reset && master_write && !master_waitrequest) begin
                if (exp_wr_addr.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected",
                             master_address, master_writedata);
                end else begin
                    check("write_addr", master_address, exp_wr_addr.pop_front());
                    check("write_data", master_writedata, exp_wr_data.pop_front());
                end
            end
            prev_stall = (master_read || master_write) && master_waitrequest;
            p_rd = master_read; p_wr = master_write;
            p_addr = master_address; p_wd = master_writedata;
            if (slave_read) begin
                if (exp_csr.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_csr_read: got 0x%0h", slave_readdata);
                end else begin
                    check("csr_read", slave_readdata, exp_csr.pop_front());
                end
            end
        end
    end

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        @(negedge clk);
        slave_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, input logic [31:0] exp);
        @(negedge clk);
        exp_csr.push_back(exp);
        slave_address = a; slave_read = 1'b1;
        @(negedge clk);
        slave_read = 1'b0;
    endtask

    task automatic cfg(input logic [31:0] wb, input logic [31:0] ab, input logic [31:0] len,
                       input logic [31:0] dest, input logic [31:0] mode);
        csr_wr(3'd1, wb); csr_wr(3'd2, ab); csr_wr(3'd3, len);
        csr_wr(3'd4, dest); csr_wr(3'd5, mode);
    endtask

    task automatic push_reads(input logic [31:0] wb, input logic [31:0] ab, input int len);
        for (int i = 0; i < len; i++) begin
            exp_raddr.push_back(wb + 32'(i * 4));
            exp_raddr.push_back(ab + 32'(i * 4));
        end
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        exp_wr_addr.push_back(a);
        exp_wr_data.push_back(d);
    endtask

    task automatic wait_irq(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk); #1;
            n++;
            if (irq) break;
        end
        check("irq_raised", irq, 1);
    endtask

    initial begin : watchdog
        #900000;
        n_checks++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : stim
        int n;
        reset = 1'b1;
        slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
        #12;
        check("rst_master_read", master_read, 0);
        check("rst_master_write", master_write, 0);
        check("rst_irq", irq, 0);
        check("rst_readdata", slave_readdata, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        csr_rd(3'd0, 32'h0);
        csr_rd(3'd6, 32'h0);

        // Scenario 1: 1.0*3.0 + 2.0*-1.0 = 1.0
        mem[32'h1000] = 32'h0200_0100;
        mem[32'h2000] = 32'hFF00_0300;
        cfg(32'h1000, 32'h2000, 1, 32'h3000, 0);
        push_reads(32'h1000, 32'h2000, 1);
        push_write(32'h3000, 32'h0000_0100);
        csr_wr(3'd0, 32'h1);
        wait_irq(50, n);
        check("latency_len1", n, 7);
        csr_rd(3'd6, 32'h0000_0100);
        csr_rd(3'd0, 32'h2);
        csr_rd(3'd7, 32'h0);
        csr_wr(3'd0, 32'h2);
        #1;
        check("irq_cleared", irq, 0);

        // Scenario 2: three words of ones -> 6.0; start together with irq clear
        for (int i = 0; i < 3; i++) begin
            mem[32'h1100 + 32'(i * 4)] = 32'h0100_0100;
            mem[32'h2100 + 32'(i * 4)] = 32'h0100_0100;
        end
        cfg(32'h1100, 32'h2100, 3, 32'h3004, 0);
        push_reads(32'h1100, 32'h2100, 3);
        push_write(32'h3004, 32'h0000_0600);
        csr_wr(3'd0, 32'h3);
        wait_irq(100, n);
        check("latency_len3", n, 17);

        // Scenario 3: negated activations, ReLU off then on
        mem[32'h2200] = 32'h0100_FD00;
        cfg(32'h1000, 32'h2200, 1, 32'h3008, 0);
        push_reads(32'h1000, 32'h2200, 1);
        push_write(32'h3008, 32'hFFFF_FF00);
        csr_wr(3'd0, 32'h1);
        #1;
        check("irq_cleared_by_start", irq, 0);
        wait_irq(50, n);
        csr_rd(3'd6, 32'hFFFF_FF00);
        csr_wr(3'd5, 32'h1);
        csr_rd(3'd5, 32'h1);
        push_reads(32'h1000, 32'h2200, 1);
        push_write(32'h3008, 32'h0000_0000);
        csr_wr(3'd0, 32'h1);
        wait_irq(50, n);
        csr_rd(3'd6, 32'h0);

        // Scenario 4: positive and negative saturation over 4096 words
        fill_en = 1'b1; fill_abase = 32'h2_0000;
        fill_w = 32'h7FFF_7FFF; fill_a = 32'h7FFF_7FFF;
        cfg(32'h1_0000, 32'h2_0000, 4096, 32'h300C, 0);
        push_reads(32'h1_0000, 32'h2_0000, 4096);
        push_write(32'h300C, 32'h7FFF_FFFF);
        csr_wr(3'd0, 32'h1);
        csr_rd(3'd0, 32'h1);
        csr_wr(3'd1, 32'hDEAD_0000);
        csr_wr(3'd0, 32'h1);
        wait_irq(30000, n);
        csr_rd(3'd1, 32'h1_0000);
        fill_w = 32'h8001_8001;
        push_reads(32'h1_0000, 32'h2_0000, 4096);
        push_write(32'h300C, 32'h8000_0000);
        csr_wr(3'd0, 32'h1);
        wait_irq(30000, n);
        fill_en = 1'b0;

        // Scenario 5: mixed-sign data under random stalls and read latency -> 0x140
        mem[32'h4000] = 32'h0180_FF80; mem[32'h5000] = 32'h0200_0300;
        mem[32'h4004] = 32'h0040_0100; mem[32'h5004] = 32'hFF00_0100;
        mem[32'h4008] = 32'h7F00_8000; mem[32'h5008] = 32'h0100_0100;
        cfg(32'h4000, 32'h5000, 3, 32'h6000, 0);
        rand_en = 1'b1;
        for (int rep = 0; rep < 4; rep++) begin
            push_reads(32'h4000, 32'h5000, 3);
            push_write(32'h6000, 32'h0000_0140);
            csr_wr(3'd0, 32'h1);
            wait_irq(400, n);
            csr_rd(3'd6, 32'h0000_0140);
        end
        rand_en = 1'b0;
        @(negedge clk);

        // Scenario 6: reset during WT_A with a stray readdatavalid afterwards
        cfg(32'h4000, 32'h5000, 2, 32'h6100, 0);
        push_reads(32'h4000, 32'h5000, 2);
        fix_delay = 5;
        watch_addr = 32'h5000;
        n = watch_cnt;
        csr_wr(3'd0, 32'h1);
        for (int c = 0; c < 50 && watch_cnt == n; c++) begin
            @(posedge clk); #2;
        end
        check("reached_rd_a", watch_cnt, n + 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_mid_read", master_read, 0);
        check("rst_mid_write", master_write, 0);
        check("rst_mid_irq", irq, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        exp_raddr.delete();
        fix_delay = 0;
        @(negedge clk); stray_req = 1'b1;
        @(negedge clk); stray_req = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_read", master_read, 0);
        check("post_rst_write", master_write, 0);
        csr_rd(3'd0, 32'h0);
        csr_rd(3'd3, 32'h0);
        csr_wr(3'd4, 32'h7000);
        push_write(32'h7000, 32'h0);
        csr_wr(3'd0, 32'h1);
        wait_irq(20, n);
        check("latency_len0", n, 2);
        csr_rd(3'd0, 32'h2);

        repeat (3) @(negedge clk);
        check("stall_stable", stall_viol, 0);
        check("one_outstanding", outstanding_viol, 0);
        check("reads_drained", exp_raddr.size(), 0);
        check("writes_drained", exp_wr_addr.size(), 0);
        check("csr_drained", exp_csr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
